// File: rtl/mc_pm_pkg.sv
// Shared definitions for the multi-rank memory-controller power manager.
//   pm_state_t   : per-rank power state
//   PM_CMD_*     : cmd_type encodings understood by the block (others ignored)
package mc_pm_pkg;

  typedef enum logic [2:0] {
    PM_ACTIVE       = 3'd0,
    PM_IDLE         = 3'd1,
    PM_POWER_DOWN   = 3'd2,
    PM_SELF_REFRESH = 3'd3,
    PM_EXIT         = 3'd4
  } pm_state_t;

  localparam logic [3:0] PM_CMD_PD   = 4'b0100;
  localparam logic [3:0] PM_CMD_SR   = 4'b0101;
  localparam logic [3:0] PM_CMD_WAKE = 4'b0110;

endpackage

// File: rtl/mc_pm_rank_fsm.sv
// One rank's power state machine with its idle and exit counters.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   activity            : rank activity this cycle (also a wake event)
//   pd_cmd/sr_cmd/wake_cmd : decoded, rank-qualified commands (one-hot at most)
//   auto_en             : enables threshold-driven entries
//   pd_threshold        : idle cycles before auto PD (0 disables)
//   sr_threshold        : idle cycles before auto SR from PD (0 disables)
//   power_down, self_refresh, rank_ready : registered state decodes
//   low_power_next      : next-cycle (power_down | self_refresh), for the
//                         registered all-rank reduction in the top
module mc_pm_rank_fsm
  import mc_pm_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TXP_CYCLES = 4,
  parameter int unsigned TXS_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             activity,
  input  logic             pd_cmd,
  input  logic             sr_cmd,
  input  logic             wake_cmd,
  input  logic             auto_en,
  input  logic [CNT_W-1:0] pd_threshold,
  input  logic [CNT_W-1:0] sr_threshold,
  output logic             power_down,
  output logic             self_refresh,
  output logic             rank_ready,
  output logic             low_power_next
);

  localparam int unsigned EXIT_MAX = (TXP_CYCLES > TXS_CYCLES) ? TXP_CYCLES : TXS_CYCLES;
  localparam int unsigned EXIT_W   = (EXIT_MAX > 1) ? $clog2(EXIT_MAX) : 1;
  localparam logic [EXIT_W-1:0] TXP_LOAD = EXIT_W'(TXP_CYCLES - 1);
  localparam logic [EXIT_W-1:0] TXS_LOAD = EXIT_W'(TXS_CYCLES - 1);

  pm_state_t         state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [EXIT_W-1:0] exit_cnt_q, exit_cnt_d;

  logic [CNT_W:0]    idle_cnt_plus1;
  logic [CNT_W-1:0]  idle_cnt_sat;
  logic              pd_auto, sr_auto, wake;
  logic              pd_d, sr_d, ready_d;

  // One extra bit so the threshold compare never wraps at all-ones.
  assign idle_cnt_plus1 = {1'b0, idle_cnt_q} + (CNT_W+1)'(1);
  assign idle_cnt_sat   = idle_cnt_plus1[CNT_W] ? idle_cnt_q : idle_cnt_plus1[CNT_W-1:0];

  assign pd_auto = auto_en && (pd_threshold != '0) && (idle_cnt_plus1 >= {1'b0, pd_threshold});
  assign sr_auto = auto_en && (sr_threshold != '0) && (idle_cnt_plus1 >= {1'b0, sr_threshold});
  assign wake    = activity || wake_cmd;

  // State and counter registers, plus the registered output decodes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PM_IDLE;
      idle_cnt_q   <= '0;
      exit_cnt_q   <= '0;
      power_down   <= 1'b0;
      self_refresh <= 1'b0;
      rank_ready   <= 1'b1;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      exit_cnt_q   <= exit_cnt_d;
      power_down   <= pd_d;
      self_refresh <= sr_d;
      rank_ready   <= ready_d;
    end
  end

  // Next-state logic. Only one command can target a rank per cycle, so the
  // PD-before-SR ordering in IDLE never competes with the SR-over-PD priority.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    exit_cnt_d = exit_cnt_q;
    unique case (state_q)
      PM_ACTIVE: begin
        if (!activity) begin
          state_d    = PM_IDLE;
          idle_cnt_d = '0;
        end
      end
      PM_IDLE: begin
        if (activity) begin
          state_d = PM_ACTIVE;
        end else if (pd_cmd) begin
          state_d = PM_POWER_DOWN;
        end else if (sr_cmd) begin
          state_d = PM_SELF_REFRESH;
        end else begin
          idle_cnt_d = idle_cnt_sat;
          // Auto SR is only evaluated from POWER_DOWN, so PD always wins here.
          if (pd_auto) state_d = PM_POWER_DOWN;
        end
      end
      PM_POWER_DOWN: begin
        if (wake) begin
          state_d    = PM_EXIT;
          exit_cnt_d = TXP_LOAD;
        end else if (sr_cmd || sr_auto) begin
          state_d = PM_SELF_REFRESH;
        end else begin
          idle_cnt_d = idle_cnt_sat;
        end
      end
      PM_SELF_REFRESH: begin
        if (wake) begin
          state_d    = PM_EXIT;
          exit_cnt_d = TXS_LOAD;
        end
      end
      PM_EXIT: begin
        if (exit_cnt_q == '0) state_d = PM_ACTIVE;
        else                  exit_cnt_d = exit_cnt_q - EXIT_W'(1);
      end
      default: begin
        state_d = PM_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they move on the same edge.
  always_comb begin
    pd_d    = (state_d == PM_POWER_DOWN);
    sr_d    = (state_d == PM_SELF_REFRESH);
    ready_d = (state_d == PM_ACTIVE) || (state_d == PM_IDLE);
  end

  assign low_power_next = pd_d | sr_d;

endmodule

// File: rtl/mc_power_manager_multi.sv
// Multi-rank power manager: one independent power FSM per rank, command
// decode per rank, and a registered all-ranks-low-power indication.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   activity         : per-rank activity
//   cmd_valid/cmd_type/cmd_rank : power command (PD / SR / wake); unknown
//                      codes and out-of-range ranks are ignored
//   auto_en, pd_threshold, sr_threshold : threshold-driven entry control
//   power_down, self_refresh, rank_ready : per-rank state outputs
//   low_power_mode   : every rank in POWER_DOWN or SELF_REFRESH
module mc_power_manager_multi
  import mc_pm_pkg::*;
#(
  parameter  int unsigned NUM_RANKS  = 4,
  parameter  int unsigned CNT_W      = 16,
  parameter  int unsigned TXP_CYCLES = 4,
  parameter  int unsigned TXS_CYCLES = 16,
  localparam int unsigned RANK_W     = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_RANKS-1:0] activity,
  input  logic                 cmd_valid,
  input  logic [3:0]           cmd_type,
  input  logic [RANK_W-1:0]    cmd_rank,
  input  logic                 auto_en,
  input  logic [CNT_W-1:0]     pd_threshold,
  input  logic [CNT_W-1:0]     sr_threshold,
  output logic [NUM_RANKS-1:0] power_down,
  output logic [NUM_RANKS-1:0] self_refresh,
  output logic [NUM_RANKS-1:0] rank_ready,
  output logic                 low_power_mode
);

  logic [NUM_RANKS-1:0] pd_cmd, sr_cmd, wake_cmd, lp_next;

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    logic hit;
    assign hit         = cmd_valid && (cmd_rank == RANK_W'(r));
    assign pd_cmd[r]   = hit && (cmd_type == PM_CMD_PD);
    assign sr_cmd[r]   = hit && (cmd_type == PM_CMD_SR);
    assign wake_cmd[r] = hit && (cmd_type == PM_CMD_WAKE);

    mc_pm_rank_fsm #(
      .CNT_W      (CNT_W),
      .TXP_CYCLES (TXP_CYCLES),
      .TXS_CYCLES (TXS_CYCLES)
    ) u_fsm (
      .clk            (clk),
      .reset_n        (reset_n),
      .activity       (activity[r]),
      .pd_cmd         (pd_cmd[r]),
      .sr_cmd         (sr_cmd[r]),
      .wake_cmd       (wake_cmd[r]),
      .auto_en        (auto_en),
      .pd_threshold   (pd_threshold),
      .sr_threshold   (sr_threshold),
      .power_down     (power_down[r]),
      .self_refresh   (self_refresh[r]),
      .rank_ready     (rank_ready[r]),
      .low_power_next (lp_next[r])
    );
  end

  // Reduced from next-state decodes so it updates on the same edge as the ranks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) low_power_mode <= 1'b0;
    else          low_power_mode <= &lp_next;
  end

endmodule
